// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory request/response,
// decode-side instruction handshake and the control-flow redirect.
//   master : the fetch sequencer (drives requests and the instruction stream)
//   slave  : memory + decode + branch unit side
interface fetch_sequencer_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc_seq;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      output inst_valid, inst_data, inst_pc, inst_pc_seq,
      input  inst_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      input  inst_valid, inst_data, inst_pc, inst_pc_seq,
      output inst_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller. Owns the fetch PC, issues one word request
// at a time to instruction memory, buffers returned words in a 2-entry FIFO
// and hands them to decode. A redirect flushes the FIFO, reloads the PC and
// discards any response still in flight.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_sequencer_if.master (imem request/response, inst
//                stream to decode, redirect)
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   fetch_sequencer_if.master          bus
);

   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [31:0]        req_pc_q;
   logic               req_valid_q, req_valid_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [31:0]        data_q [DEPTH];
   logic [31:0]        pc_q   [DEPTH];

   logic               accept_c;
   logic               pop_c;
   logic               push_c;
   logic [31:0]        redir_pc_c;

   assign accept_c   = req_valid_q & bus.imem_req_ready;
   assign pop_c      = (count_q != '0) & bus.inst_ready;
   assign redir_pc_c = {bus.redirect_pc[31:2], 2'b00};

   // State register: FSM, PC, FIFO occupancy and the registered request valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_REQ;
         fetch_pc_q  <= RESET_PC;
         req_valid_q <= 1'b0;
         count_q     <= '0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         req_valid_q <= req_valid_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
      end
   end

   // Next-state logic; redirect overrides every PC/FIFO update last
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      push_c      = 1'b0;
      req_valid_d = 1'b0;

      case (state_q)
         S_REQ: begin
            if (accept_c) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = bus.redirect ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_resp_valid) begin
               push_c  = ~bus.redirect;
               state_d = S_REQ;
            end else if (bus.redirect) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (bus.imem_resp_valid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      if (push_c) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop_c) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (bus.redirect) begin
         fetch_pc_d = redir_pc_c;
         count_d    = '0;
         rd_ptr_d   = 1'b0;
         wr_ptr_d   = 1'b0;
      end

      // Registered so the request never depends combinationally on an input
      req_valid_d = (state_d == S_REQ) && (count_d < CNT_W'(DEPTH));
   end

   // PC of the outstanding request and FIFO storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_pc_q  <= '0;
         data_q[0] <= '0;
         data_q[1] <= '0;
         pc_q[0]   <= '0;
         pc_q[1]   <= '0;
      end else begin
         if (accept_c) begin
            req_pc_q <= fetch_pc_q;
         end
         if (push_c) begin
            data_q[wr_ptr_q] <= bus.imem_resp_data;
            pc_q[wr_ptr_q]   <= req_pc_q;
         end
      end
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.inst_valid     = (count_q != '0);
   assign bus.inst_data      = data_q[rd_ptr_q];
   assign bus.inst_pc        = pc_q[rd_ptr_q];
   assign bus.inst_pc_seq    = pc_q[rd_ptr_q] + 32'd4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer. The stimulus process drives the bus
// on the falling edge; the monitor process observes every handshake shortly
// after and compares against a program-order model: requests walk upward from
// the last redirect target, each surviving response becomes the next expected
// instruction, and a redirect empties the expected queue.
module tb_fetch_sequencer;

   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
   } item_t;

   logic clk;
   logic rst_n;

   fetch_sequencer_if b ();

   fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   int          n_chk = 0;
   int          n_err = 0;

   item_t       q[$];
   logic [31:0] exp_req_pc  = 32'h0;
   logic        mem_pending = 1'b0;
   logic        mem_live    = 1'b0;
   int          mem_delay   = 0;
   logic [31:0] mem_addr    = 32'h0;
   logic [31:0] mem_pc     = 32'h0;
   int          lat_max     = 0;
   logic        mon_en      = 1'b0;
   int          cyc         = 0;
   int          first_iv    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: cycle budget expired at %0t", name, $time);
   endtask

   // One cycle of stimulus; the memory answers when its latency expires
   task automatic drive(input logic rdy, input logic ird, input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      b.imem_req_ready  = rdy;
      b.inst_ready      = ird;
      b.redirect        = rd;
      b.redirect_pc     = rpc;
      b.imem_resp_valid = mem_pending && (mem_delay == 0);
      b.imem_resp_data  = mem_pending ? mem_word(mem_addr) : 32'hDEAD_BEEF;
      #3;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (q.size() != 0 || mem_pending); i++)
         drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (q.size() != 0 || mem_pending) bound_fail("drain");
   endtask

   task automatic model_reset();
      q.delete();
      exp_req_pc  = 32'h0;
      mem_pending = 1'b0;
      mem_live    = 1'b0;
      mem_delay   = 0;
   endtask

   // Monitor: checks every observed handshake, then advances the model
   initial begin
      item_t e;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            cyc++;
            chk("inst_valid", 32'(b.inst_valid), 32'(q.size() != 0));
            chk("req_valid", 32'(b.imem_req_valid), 32'(!mem_pending && q.size() < 2));
            if (b.inst_valid && first_iv == 0) first_iv = cyc;

            if (b.inst_valid && b.inst_ready) begin
               if (q.size() == 0) begin
                  bound_fail("pop_unexpected");
               end else begin
                  e = q.pop_front();
                  chk("inst_data", b.inst_data, e.data);
                  chk("inst_pc", b.inst_pc, e.pc);
                  chk("inst_pc_seq", b.inst_pc_seq, e.pc + 32'd4);
               end
            end

            if (mem_pending && b.imem_resp_valid) begin
               if (mem_live && !b.redirect) begin
                  e.data = mem_word(mem_pc);
                  e.pc   = mem_pc;
                  q.push_back(e);
               end
               mem_pending = 1'b0;
            end else if (mem_pending) begin
               mem_delay--;
            end

            if (b.imem_req_valid && b.imem_req_ready) begin
               chk("req_addr", b.imem_req_addr, exp_req_pc);
               mem_pending = 1'b1;
               mem_live    = !b.redirect;
               mem_addr    = b.imem_req_addr;
               mem_pc      = exp_req_pc;
               mem_delay   = (lat_max == 0) ? 0 : int'($urandom_range(lat_max, 0));
               exp_req_pc  = exp_req_pc + 32'd4;
            end

            if (b.redirect) begin
               q.delete();
               exp_req_pc = b.redirect_pc & 32'hFFFF_FFFC;
               mem_live   = 1'b0;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n             = 1'b0;
      b.imem_req_ready  = 1'b0;
      b.imem_resp_valid = 1'b0;
      b.imem_resp_data  = 32'h0;
      b.inst_ready      = 1'b0;
      b.redirect        = 1'b0;
      b.redirect_pc     = 32'h0;
      #1;
      chk("rst_req_valid", 32'(b.imem_req_valid), 32'h0);
      chk("rst_inst_valid", 32'(b.inst_valid), 32'h0);
      chk("rst_req_addr", b.imem_req_addr, 32'h0);
      chk("rst_inst_data", b.inst_data, 32'h0);
      chk("rst_inst_pc", b.inst_pc, 32'h0);

      // Stream from reset: 1-cycle memory, decode always ready
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n            = 1'b1;
      b.imem_req_ready = 1'b1;
      b.inst_ready     = 1'b1;
      @(posedge clk);
      mon_en = 1'b1;
      repeat (20) drive(1'b1, 1'b1, 1'b0, 32'h0);
      chk("first_inst_valid_cycle", 32'(first_iv), 32'd3);

      // Backpressure: fetching must stop at two buffered words, then resume
      repeat (12) drive(1'b1, 1'b0, 1'b0, 32'h0);
      chk("bp_buffer_full", 32'(b.inst_valid), 32'h1);
      repeat (12) drive(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect while a request is outstanding and not yet answered
      lat_max = 3;
      for (int i = 0; i < 50 && !(mem_pending && mem_delay > 0); i++)
         drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (!(mem_pending && mem_delay > 0)) bound_fail("setup_redirect_wait");
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0103);
      repeat (15) drive(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect coinciding with a response and a pop while one word is buffered
      drain();
      lat_max = 0;
      for (int i = 0; i < 50 && !(mem_pending && mem_delay == 0 && q.size() == 1); i++)
         drive(1'b1, 1'b0, 1'b0, 32'h0);
      if (!(mem_pending && mem_delay == 0 && q.size() == 1)) bound_fail("setup_redirect_pop");
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
      repeat (10) drive(1'b1, 1'b1, 1'b0, 32'h0);

      // PC wrap at the top of the address space
      drain();
      drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      repeat (12) drive(1'b1, 1'b1, 1'b0, 32'h0);

      // Random traffic
      lat_max = 3;
      for (int i = 0; i < 3000; i++)
         drive(1'($urandom_range(99, 0) < 70), 1'($urandom_range(99, 0) < 60),
               1'($urandom_range(99, 0) < 5), $urandom);

      // Reset asserted mid-cycle while dropping an abandoned response
      for (int i = 0; i < 80 && !(mem_pending && mem_delay >= 2); i++)
         drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (!(mem_pending && mem_delay >= 2)) bound_fail("setup_drop");
      drive(1'b1, 1'b1, 1'b1, 32'h0000_2000);
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("async_rst_req_valid", 32'(b.imem_req_valid), 32'h0);
      chk("async_rst_inst_valid", 32'(b.inst_valid), 32'h0);
      chk("async_rst_req_addr", b.imem_req_addr, 32'h0);
      b.imem_req_ready  = 1'b0;
      b.inst_ready      = 1'b1;
      b.redirect        = 1'b0;
      b.imem_resp_valid = 1'b1;
      b.imem_resp_data  = 32'hBAD0_BAD0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #2;
         chk("stale_resp_inst_valid", 32'(b.inst_valid), 32'h0);
      end
      b.imem_resp_valid = 1'b0;
      @(posedge clk);
      mon_en = 1'b1;
      repeat (30) drive(1'b1, 1'b1, 1'b0, 32'h0);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch controller for the processor front end. It owns the fetch PC and issues word requests to an instruction memory with a valid/ready handshake, allowing at most one request outstanding. Returned instructions are buffered in a 2-entry FIFO and delivered to decode with a valid/ready handshake. Branch and jump redirects flush the buffer, reload the PC and discard any in-flight response.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset. Bits [1:0] must be 0.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word address of the request. Bits [1:0] are always 0.
- imem_resp_valid  in  1  response data valid. Responses return in order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  buffer head is valid.
- inst_ready  in  1  decode consumes the head.
- inst_data  out  32  instruction at the buffer head.
- inst_pc  out  32  address of inst_data.
- inst_pc_seq  out  32  inst_pc + 4, modulo 2^32.
- redirect  in  1  control-flow change. Takes effect at the end of this cycle.
- redirect_pc  in  32  new fetch address. Bits [1:0] are ignored and forced to 0.

## Operation
- State: fetch_pc (32 bits); FIFO of {instr, pc} (2 entries) with count 0..2; FSM with states REQ, WAIT, DROP.
- imem_req_valid = (state==REQ) && (count<2). It comes only from registers, with no combinational path from any input. imem_req_addr = fetch_pc.
- REQ:
  - Accept (req_valid & req_ready) with no redirect: fetch_pc += 4 (wraps at 2^32), go to WAIT.
  - Accept in the same cycle as redirect: go to DROP, fetch_pc = redirect_pc.
- WAIT:
  - resp_valid with no redirect: push {resp_data, pc of request} into the FIFO, go to REQ.
  - resp_valid together with redirect: discard the data, go to REQ.
  - redirect without resp_valid: go to DROP.
- DROP:
  - resp_valid: discard the data, go to REQ.
  - redirect: update fetch_pc and stay in DROP.
- Redirect in any state:
  - FIFO count becomes 0.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Flush takes priority over a simultaneous push or pop.
- FIFO:
  - inst_valid = (count != 0). inst_data, inst_pc and inst_pc_seq are taken from the head entry.
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - A push is never attempted when full, because a request is only issued while count<2.
- Outputs are undefined-but-stable when inst_valid=0. They must not be X after reset (all entries reset to 0).

## Timing
- Reset values (async on rst_n=0):
  - fetch_pc=RESET_PC, count=0, state=REQ.
  - imem_req_valid=0 while rst_n=0. inst_valid=0.
  - All FIFO entries 0.
- First request: imem_req_valid=1 in the first cycle after rst_n rises, with addr=RESET_PC.
- Response at edge N: inst_valid=1 from cycle N+1 (registered FIFO, no bypass).
- Throughput: one instruction per 2 cycles with a 1-cycle memory (one outstanding request).
- Redirect at edge N: inst_valid=0 in cycle N+1.
  - The new request with addr=redirect_pc is issued in cycle N+1 if nothing is outstanding.
  - Otherwise it is issued in the cycle after the discarded response.
- Reset asserted mid-transaction: everything is abandoned immediately. A response arriving after reset release with no outstanding request (state REQ) is ignored.
- Backpressure: with inst_ready=0, fetching stops after 2 buffered instructions and imem_req_valid stays 0 until a pop.

## Test plan
- Reset/stream: RESET_PC=0, memory ready=1 with 1-cycle latency, inst_ready=1 -> requests at 0,4,8,... on alternate cycles; inst_pc 0,4,8 with inst_pc_seq 4,8,12; first inst_valid 3 cycles after reset release.
- Backpressure: inst_ready=0 -> exactly 2 requests (0,4), count=2, req_valid low. Raising inst_ready delivers 0 then 4, then the request for 8 resumes.
- Redirect while waiting: redirect to 32'h0000_0103 while in WAIT -> the response for the old PC is dropped, the next request addr=0x100, and the FIFO is empty the next cycle.
- Redirect with simultaneous response and pop: count=1, resp_valid=1, inst_ready=1, redirect to 0x40 in one cycle -> count=0, no push, next addr=0x40.
- Wrap: redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000; inst_pc_seq for the first = 0x0000_0000.
- Async reset in DROP: assert rst_n=0 mid-cycle -> outputs take reset values without a clock edge; a stale resp_valid after release produces no inst_valid.
